// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampled UART blocks.
//   rx_state_t   receiver FSM state encoding
//   OSR          oversample ratio (ticks per bit time)
//   TICK_*       tick indices within a bit time used for sampling/advance
//   maj3()       3-input majority vote
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OSR = 16;

  // Samples are taken at ticks 7, 8 and 9 (centre of the bit); the vote is
  // resolved at tick 9 and the FSM advances to the next bit at tick 15.
  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_S2   = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'd15;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator, shared by UART RX and TX.
// Emits a one-cycle tick every CLK_FREQ/(UART_BPS*OSR) clocks.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   clear  restart the divider (phase-aligns ticks to a start edge)
//   tick   one-cycle oversample strobe
module uart_baud_tick #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int OSR      = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int         TICK_DIV = CLK_FREQ / (UART_BPS * OSR);
  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (cnt_reg == DIV_LAST) begin
      cnt_reg <= '0;
      tick    <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: parametrised UART receiver, 16x oversampling with 3-sample
// majority vote, start-bit glitch rejection, framing/parity error flags.
// Optional feature macro: UART_RX_PARITY_EN (one parity bit after the data
// bits, even or odd per PARITY_ODD). Without it parity_err is tied to 0.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   uart_rxd    serial input (asynchronous, idle high)
//   rx_valid    one-cycle pulse per delivered word
//   rx_data     received word (LSB first on the line), held until next pulse
//   frame_err   a stop bit voted low; valid with rx_valid, held with rx_data
//   parity_err  parity mismatch; valid with rx_valid, held with rx_data
//   rx_busy     receiver is inside a frame
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  // Synchroniser and edge register reset to 1 so reset release never looks
  // like a falling edge.
  logic rxd_meta_reg, rxd_sync_reg, rxd_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= uart_rxd;
      rxd_sync_reg <= rxd_meta_reg;
      rxd_prev_reg <= rxd_sync_reg;
    end
  end

  logic fall;
  assign fall = rxd_prev_reg & ~rxd_sync_reg;

  rx_state_t            state_reg;
  logic [3:0]           bit_tick_reg;
  logic [3:0]           bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 samp_a_reg, samp_b_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 fe_acc_reg;
  logic                 pe_acc_reg;
  logic                 tick;
  logic                 start_det;
  logic                 maj;
  logic                 fe_now;

  // Only a falling edge seen while idle starts a frame; a line held low
  // after a framing error therefore cannot retrigger.
  assign start_det = (state_reg == IDLE) && fall;

  // Third sample is the live synchronised line at tick 9.
  assign maj    = maj3(samp_a_reg, samp_b_reg, rxd_sync_reg);
  assign fe_now = fe_acc_reg | ~maj;

  uart_baud_tick #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .OSR      (OSR)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_det),
    .tick  (tick)
  );

`ifndef UART_RX_PARITY_EN
  logic unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_tick_reg <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      samp_a_reg   <= 1'b1;
      samp_b_reg   <= 1'b1;
      shift_reg    <= '0;
      fe_acc_reg   <= 1'b0;
      pe_acc_reg   <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      frame_err    <= 1'b0;
      parity_err   <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_busy  <= (state_reg != IDLE);

      if (state_reg == IDLE) begin
        if (fall) begin
          state_reg    <= START;
          bit_tick_reg <= '0;
          bit_cnt_reg  <= '0;
          stop_cnt_reg <= 1'b0;
          fe_acc_reg   <= 1'b0;
          pe_acc_reg   <= 1'b0;
        end
      end else if (tick) begin
        // 4-bit index wraps 15 -> 0 at each bit boundary.
        bit_tick_reg <= bit_tick_reg + 4'd1;
        if (bit_tick_reg == TICK_S0) samp_a_reg <= rxd_sync_reg;
        if (bit_tick_reg == TICK_S1) samp_b_reg <= rxd_sync_reg;

        case (state_reg)
          START: begin
            if (bit_tick_reg == TICK_S2 && maj)
              state_reg <= IDLE;               // glitch, not a real start bit
            else if (bit_tick_reg == TICK_LAST)
              state_reg <= DATA;
          end

          DATA: begin
            if (bit_tick_reg == TICK_S2)
              shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            if (bit_tick_reg == TICK_LAST) begin
              if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 4'd1;
              end
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            // Even: parity bit must equal XOR of data; odd: its inverse.
            if (bit_tick_reg == TICK_S2)
              pe_acc_reg <= maj ^ (^shift_reg) ^ 1'(PARITY_ODD);
            if (bit_tick_reg == TICK_LAST)
              state_reg <= STOP;
          end
`endif

          STOP: begin
            if (bit_tick_reg == TICK_S2) begin
              if (stop_cnt_reg == STOP_LAST) begin
                // Deliver at the centre of the last stop bit so the next
                // start edge is caught during the second half of it.
                rx_data    <= shift_reg;
                frame_err  <= fe_now;
                parity_err <= pe_acc_reg;
                rx_valid   <= 1'b1;
                state_reg  <= IDLE;
              end else begin
                fe_acc_reg <= fe_now;
              end
            end
            if (bit_tick_reg == TICK_LAST)
              stop_cnt_reg <= stop_cnt_reg + 1'b1;
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench for uart_rx_os.
// Instance A: 8 data bits, 1 stop. Instance B: 7 data bits, 2 stop.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 27 * 16;   // 50 MHz / 115200 baud, 16x oversampling

  logic       clk;
  logic       rst_n;
  logic       rxd_a, rxd_b;
  logic       rx_valid_a, frame_err_a, parity_err_a, rx_busy_a;
  logic [7:0] rx_data_a;
  logic       rx_valid_b, frame_err_b, parity_err_b, rx_busy_b;
  logic [6:0] rx_data_b;

  int errors = 0;
  int checks = 0;

  int         cnt_a = 0;
  int         cnt_b = 0;
  int         consec = 0;
  logic       prev_valid_a = 1'b0;
  logic       prev_valid_b = 1'b0;
  logic [7:0] last_data_a;
  logic       last_fe_a, last_pe_a;
  logic [6:0] dat_b [4];
  logic       fe_b [4];

  uart_rx_os #(
    .CLK_FREQ (50000000), .UART_BPS (115200),
    .DATA_BITS (8), .STOP_BITS (1), .PARITY_ODD (0)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .uart_rxd (rxd_a),
    .rx_valid (rx_valid_a), .rx_data (rx_data_a),
    .frame_err (frame_err_a), .parity_err (parity_err_a), .rx_busy (rx_busy_a)
  );

  uart_rx_os #(
    .CLK_FREQ (50000000), .UART_BPS (115200),
    .DATA_BITS (7), .STOP_BITS (2), .PARITY_ODD (0)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .uart_rxd (rxd_b),
    .rx_valid (rx_valid_b), .rx_data (rx_data_b),
    .frame_err (frame_err_b), .parity_err (parity_err_b), .rx_busy (rx_busy_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Received-word monitor: one line per delivered word.
  always @(negedge clk) begin
    if (rx_valid_a) begin
      cnt_a++;
      last_data_a = rx_data_a;
      last_fe_a   = frame_err_a;
      last_pe_a   = parity_err_a;
      $display("rx A word %0d: data=0x%02h frame_err=%0b parity_err=%0b",
               cnt_a, rx_data_a, frame_err_a, parity_err_a);
    end
    if (rx_valid_b) begin
      if (cnt_b < 4) begin
        dat_b[cnt_b] = rx_data_b;
        fe_b[cnt_b]  = frame_err_b;
      end
      cnt_b++;
      $display("rx B word %0d: data=0x%02h frame_err=%0b parity_err=%0b",
               cnt_b, rx_data_b, frame_err_b, parity_err_b);
    end
    if ((rx_valid_a && prev_valid_a) || (rx_valid_b && prev_valid_b)) consec++;
    prev_valid_a = rx_valid_a;
    prev_valid_b = rx_valid_b;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit sel_b, input logic v, input int nclks);
    if (sel_b) rxd_b = v;
    else       rxd_a = v;
    wait_clks(nclks);
  endtask

  task automatic send_frame(input bit sel_b, input logic [8:0] data, input int nbits,
                            input int nstop, input logic stop_val, input logic par_flip);
    logic p;
    p = 1'b0;
    drive_bit(sel_b, 1'b0, BIT_CLKS);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(sel_b, data[i], BIT_CLKS);
      p = p ^ data[i];
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(sel_b, p ^ par_flip, BIT_CLKS);
`else
    if (par_flip) $display("note: parity bit requested but frame has no parity (p=%0b)", p);
`endif
    for (int i = 0; i < nstop; i++) drive_bit(sel_b, stop_val, BIT_CLKS);
    if (sel_b) rxd_b = 1'b1;
    else       rxd_a = 1'b1;
  endtask

  initial begin
    logic [7:0] c3;
    int         base;
    rst_n = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);

    // Reset state
    check("rst_valid",  {31'd0, rx_valid_a},   32'd0);
    check("rst_data",   {24'd0, rx_data_a},    32'd0);
    check("rst_fe",     {31'd0, frame_err_a},  32'd0);
    check("rst_pe",     {31'd0, parity_err_a}, 32'd0);
    check("rst_busy",   {31'd0, rx_busy_a},    32'd0);

    // Clean 0x55
    send_frame(1'b0, 9'h055, 8, 1, 1'b1, 1'b0);
    wait_clks(50);
    check("w55_count", cnt_a, 1);
    check("w55_data",  {24'd0, last_data_a}, 32'h55);
    check("w55_fe",    {31'd0, last_fe_a},   32'd0);
    check("w55_pe",    {31'd0, last_pe_a},   32'd0);

    // Two-tick low glitch must be rejected
    wait_clks(BIT_CLKS);
    rxd_a = 1'b0;
    wait_clks(2 * 27);
    rxd_a = 1'b1;
    wait_clks(BIT_CLKS - 2 * 27);
    check("glitch_count", cnt_a, 1);
    check("glitch_busy",  {31'd0, rx_busy_a}, 32'd0);

    // 0xA3 with low stop bit, then clean 0x0F
    send_frame(1'b0, 9'h0A3, 8, 1, 1'b0, 1'b0);
    wait_clks(BIT_CLKS);
    check("wA3_count", cnt_a, 2);
    check("wA3_data",  {24'd0, last_data_a}, 32'hA3);
    check("wA3_fe",    {31'd0, last_fe_a},   32'd1);
    send_frame(1'b0, 9'h00F, 8, 1, 1'b1, 1'b0);
    wait_clks(50);
    check("w0F_count", cnt_a, 3);
    check("w0F_data",  {24'd0, last_data_a}, 32'h0F);
    check("w0F_fe",    {31'd0, last_fe_a},   32'd0);

`ifdef UART_RX_PARITY_EN
    // 0xA5 has four ones: even parity bit 0 is correct, 1 is wrong
    wait_clks(BIT_CLKS);
    send_frame(1'b0, 9'h0A5, 8, 1, 1'b1, 1'b0);
    wait_clks(50);
    check("par_ok_data", {24'd0, last_data_a}, 32'hA5);
    check("par_ok_pe",   {31'd0, last_pe_a},   32'd0);
    wait_clks(BIT_CLKS);
    send_frame(1'b0, 9'h0A5, 8, 1, 1'b1, 1'b1);
    wait_clks(50);
    check("par_bad_data", {24'd0, last_data_a}, 32'hA5);
    check("par_bad_pe",   {31'd0, last_pe_a},   32'd1);
`endif

    // 7N2 back-to-back 0x7F, 0x01 on instance B
    send_frame(1'b1, 9'h07F, 7, 2, 1'b1, 1'b0);
    send_frame(1'b1, 9'h001, 7, 2, 1'b1, 1'b0);
    wait_clks(50);
    check("b2b_count", cnt_b, 2);
    check("b2b_data0", {25'd0, dat_b[0]}, 32'h7F);
    check("b2b_fe0",   {31'd0, fe_b[0]},  32'd0);
    check("b2b_data1", {25'd0, dat_b[1]}, 32'h01);
    check("b2b_fe1",   {31'd0, fe_b[1]},  32'd0);

    // Reset during data bit 4 of 0xC3
    wait_clks(BIT_CLKS);
    base = cnt_a;
    c3 = 8'hC3;
    drive_bit(1'b0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, c3[i], BIT_CLKS);
    drive_bit(1'b0, c3[4], 200);
    check("mid_busy_before", {31'd0, rx_busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rx_valid_a},  32'd0);
    check("mid_rst_data",  {24'd0, rx_data_a},   32'd0);
    check("mid_rst_fe",    {31'd0, frame_err_a}, 32'd0);
    check("mid_rst_busy",  {31'd0, rx_busy_a},   32'd0);
    wait_clks(10);
    rst_n = 1'b1;
    rxd_a = 1'b1;
    wait_clks(4 * BIT_CLKS);
    check("mid_no_word", cnt_a, base);
    send_frame(1'b0, 9'h03C, 8, 1, 1'b1, 1'b0);
    wait_clks(50);
    check("w3C_count", cnt_a, base + 1);
    check("w3C_data",  {24'd0, last_data_a}, 32'h3C);
    check("w3C_fe",    {31'd0, last_fe_a},   32'd0);
    check("w3C_pe",    {31'd0, last_pe_a},   32'd0);

    check("valid_consecutive", consec, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised UART receiver for the serial I/O datapath. It succeeds the fixed 8N1 receiver with configurable data width and stop bit count, 16x oversampling with 3-sample majority voting, and start-bit glitch rejection. It reports framing and parity errors alongside each received word. It sits between the board RX pin and the loopback or transmit path, which consumes one `rx_valid` pulse per word.

## Interface
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 115200: baud rate.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when `UART_RX_PARITY_EN` is defined.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `uart_rxd`, input, 1: asynchronous serial input, idle high.
- `rx_valid`, output, 1: one-cycle pulse when a word is delivered.
- `rx_data`, output, DATA_BITS: received word, LSB first on the line. Held until the next `rx_valid`.
- `frame_err`, output, 1: any stop bit sampled low. Qualified by `rx_valid` and held with `rx_data`.
- `parity_err`, output, 1: parity mismatch. Qualified by `rx_valid` and held with `rx_data`.
- `rx_busy`, output, 1: high while the FSM is not in IDLE.

## Operation
- Input path is a 2-flop synchroniser plus an edge register, all reset to 1. A reset value of 1 guarantees no false start after reset.
- The oversample tick fires every `TICK_DIV = CLK_FREQ/(UART_BPS*16)` clocks. The tick counter is 16 bits wide and restarts at start detection.
- Bit time is 16 ticks, indexed 0..15. At ticks 7, 8 and 9 the synchronised line is sampled. The bit value is the majority of those 3 samples, resolved at tick 9.
- FSM states and transitions:
  - IDLE -> START on a synchronised falling edge.
  - START -> IDLE if the start-bit majority is 1 (glitch rejected, no output). START -> DATA at tick 15 if the majority is 0.
  - DATA: shifts right into a DATA_BITS register, one bit per bit time. Moves to PARITY after bit DATA_BITS-1 if parity is enabled, otherwise to STOP.
  - PARITY: compares the received bit with the computed XOR (inverted for odd parity), then moves to STOP.
  - STOP: evaluates each stop bit. `frame_err` is set if any stop majority is 0.
- At tick 9 of the last stop bit, in the same cycle:
  - `rx_data`, `frame_err` and `parity_err` load.
  - `rx_valid` pulses.
  - The FSM returns to IDLE.
  
  Because of this, a new start edge is detected during the remaining half of the stop bit.
- A frame with `frame_err` is still delivered. It is never dropped.
- A line stuck low after a framing error does not retrigger. A falling edge is required to leave IDLE.

## Timing
- Reset values: `rx_valid`=0, `rx_data`=0, `frame_err`=0, `parity_err`=0, `rx_busy`=0, FSM in IDLE.
- Start detection occurs 3 clocks after the pin's falling edge (2 synchroniser flops plus the edge register). `rx_busy` rises in the following cycle.
- Latency from pin start edge to `rx_valid` is `(1 + DATA_BITS + P + STOP_BITS - 1)*16 + 10` ticks plus 4 clocks, where P is 1 if parity is enabled and 0 otherwise.
- Reset asserted mid-frame: all state clears immediately and no partial word is emitted. After release, the receiver waits for a fresh falling edge.
- `rx_valid` is never asserted on two consecutive cycles. There is no backpressure, so the consumer must accept every pulse.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, one parity bit follows the data bits, and `parity_err` is computed per `PARITY_ODD`.
- `UART_RX_PARITY_EN` undefined: the frame has no parity bit, the PARITY state and its logic are absent, and `parity_err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - `OSR=16`;
  - sample tick constants 7, 8, 9 and 15.
- Sub-module `uart_baud_tick` (parameters CLK_FREQ, UART_BPS, OSR; inputs `clk`, `rst_n`, `clear`; output `tick`) generates the oversample tick. It is shared with the future oversampled transmitter.

## Test plan
- 8N1 at 115200 baud with 50 MHz clock (TICK_DIV=27), send 0x55 -> exactly one `rx_valid`, `rx_data`=0x55, `frame_err`=0, `parity_err`=0.
- Low glitch of 2 ticks on an idle line -> no `rx_valid`, `rx_busy` returns to 0 within 1 bit time.
- Send 0xA3 with the stop bit driven low -> `rx_valid` with `rx_data`=0xA3 and `frame_err`=1. A following clean 0x0F arrives with `frame_err`=0.
- Parity enabled, even parity: 0xA5 with parity bit 0 -> `parity_err`=0; the same word with parity bit 1 -> `parity_err`=1.
- DATA_BITS=7, STOP_BITS=2, back-to-back words 0x7F then 0x01 with no idle gap -> two pulses carrying 0x7F then 0x01, `frame_err`=0 on both.
- `rst_n` asserted during data bit 4 of 0xC3 -> no `rx_valid`, outputs at reset values. A subsequent 0x3C is received correctly.
